// File: rtl/mbscore_int_arbiter_pkg.sv
// Shared constants for the interrupt arbiter and its consumers.
//   - Default source count and vector width.
//   - Vector codes: each source bit index i maps to code i+1, and code 0 means no interrupt.
//   - Arbiter FSM state encoding.
package mbscore_int_arbiter_pkg;

    localparam int unsigned NumSrc   = 7;
    localparam int unsigned VecWidth = 3;

    typedef logic [VecWidth-1:0] vec_t;

    // Source bit 0 (syscall) has the highest priority.
    localparam vec_t VecNone    = 3'd0;
    localparam vec_t IntSyscall = 3'd1;
    localparam vec_t IntTimer   = 3'd2;
    localparam vec_t IntUart    = 3'd3;
    localparam vec_t IntSpi     = 3'd4;
    localparam vec_t IntGpio    = 3'd5;
    localparam vec_t IntExt     = 3'd6;
    localparam vec_t IntCf      = 3'd7;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mbscore_prio_enc.sv
// Combinational lowest-index-first priority encoder.
//   req_i   : request vector, bit 0 has the highest priority
//   valid_o : at least one request bit is set
//   idx_o   : index of the lowest set bit; 0 when valid_o is low
module mbscore_prio_enc #(
    parameter int unsigned NSrc = 7,
    parameter int unsigned VecW = 3
) (
    input  logic [NSrc-1:0] req_i,
    output logic            valid_o,
    output logic [VecW-1:0] idx_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = NSrc - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = VecW'(i);
            end
        end
    end

endmodule

// File: rtl/mbscore_int_arbiter.sv
// Interrupt arbiter: latches rising edges of the request lines as pending, applies the software
// mask and fixed priority, and offers one vector at a time to the core interrupt controller.
// After the core acknowledges, no further vector is offered until the handler returns.
//   clk_i        : clock, all logic on posedge
//   rst_i        : synchronous active-high reset
//   irq_in_i     : level requests; a 0->1 transition sets the pending bit
//   mask_we_i    : mask write strobe; new mask applies from the next cycle
//   mask_wdata_i : new mask value, 1 = source enabled
//   gie_i        : global interrupt enable from the core
//   int_ack_i    : core took the jump for the offered vector (pulse)
//   int_done_i   : handler returned (pulse)
//   int_vec_o    : offered vector code, 0 when nothing is offered
//   int_en_n_o   : low while int_vec_o is being offered
//   pending_o    : pending register for status reads
//   in_service_o : high from acknowledge until done
module mbscore_int_arbiter
    import mbscore_int_arbiter_pkg::*;
#(
    parameter int unsigned NSrc = NumSrc,
    parameter int unsigned VecW = VecWidth
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NSrc-1:0] irq_in_i,
    input  logic            mask_we_i,
    input  logic [NSrc-1:0] mask_wdata_i,
    input  logic            gie_i,
    input  logic            int_ack_i,
    input  logic            int_done_i,
    output logic [VecW-1:0] int_vec_o,
    output logic            int_en_n_o,
    output logic [NSrc-1:0] pending_o,
    output logic            in_service_o
);

    logic [NSrc-1:0] irq_d_q;
    logic [NSrc-1:0] mask_q;
    logic [NSrc-1:0] pending_q, pending_d;
    logic [VecW-1:0] sel_q;
    logic [VecW-1:0] int_vec_q;
    logic            int_en_n_q;
    logic            in_service_q;
    arb_state_e      state_q;

    logic [NSrc-1:0] irq_rise;
    logic [NSrc-1:0] pend_clr;
    logic [NSrc-1:0] elig;
    logic            win_valid;
    logic [VecW-1:0] win_idx;
    logic            take_ack;

    assign irq_rise = irq_in_i & ~irq_d_q;
    assign elig     = pending_q & mask_q;
    assign take_ack = (state_q == StReq) && int_ack_i;

    mbscore_prio_enc #(
        .NSrc (NSrc),
        .VecW (VecW)
    ) u_prio_enc (
        .req_i   (elig),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    // Clear is applied after set, so a new edge on the bit being acknowledged is dropped on
    // purpose: the handler about to run services that source anyway. Edges on other bits are
    // kept.
    always_comb begin
        pend_clr = '0;
        if (take_ack) begin
            pend_clr[sel_q] = 1'b1;
        end
        pending_d = (pending_q | irq_rise) & ~pend_clr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_d_q      <= '0;
            mask_q       <= '0;
            pending_q    <= '0;
            sel_q        <= '0;
            int_vec_q    <= '0;
            int_en_n_q   <= 1'b1;
            in_service_q <= 1'b0;
            state_q      <= StIdle;
        end else begin
            irq_d_q   <= irq_in_i;
            pending_q <= pending_d;
            if (mask_we_i) begin
                mask_q <= mask_wdata_i;
            end

            unique case (state_q)
                StIdle: begin
                    if (gie_i && win_valid) begin
                        state_q    <= StReq;
                        sel_q      <= win_idx;
                        int_vec_q  <= win_idx + VecW'(1);
                        int_en_n_q <= 1'b0;
                    end
                end
                StReq: begin
                    // The offered vector is frozen; a higher-priority arrival does not replace
                    // it. Acknowledge takes precedence over withdrawal.
                    if (int_ack_i) begin
                        state_q      <= StService;
                        int_vec_q    <= '0;
                        int_en_n_q   <= 1'b1;
                        in_service_q <= 1'b1;
                    end else if (!gie_i || !elig[sel_q]) begin
                        state_q    <= StIdle;
                        int_vec_q  <= '0;
                        int_en_n_q <= 1'b1;
                    end
                end
                StService: begin
                    if (int_done_i) begin
                        state_q      <= StIdle;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    int_vec_q  <= '0;
                    int_en_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign int_vec_o    = int_vec_q;
    assign int_en_n_o   = int_en_n_q;
    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule
